mii_rx_deframer: RTL and testbench
==================================

// Module: mii_rx_deframer
// PURPOSE
//  MII receive deframer between the RMII-to-MII converter and the Ethernet receive logic in hermes_lite_core.
//  Consumes 4-bit MII nibbles plus data-valid and strips preamble/SFD.
//  Assembles bytes low nibble first, checks CRC-32, length and alignment.
//  Emits a byte stream with start/end-of-frame strobes and per-frame status.
// PARAMETERS
//  PRE_MIN  6     min count of 0x5 preamble nibbles required before SFD nibble 0xD
//  MIN_LEN  64    min legal frame length in bytes, DA..FCS inclusive
//  MAX_LEN  1518  max legal frame length in bytes, DA..FCS inclusive
// PORTS
//  clk           in   1   rmii_osc (50 MHz); the only clock
//  resetn        in   1   reset, synchronous, active-low
//  nib_en        in   1   nibble strobe, one clk per MII nibble; rxd/rx_dv valid only when high
//  rxd           in   4   MII receive nibble (PHY_RX)
//  rx_dv         in   1   MII data valid (RX_DV)
//  rx_data       out  8   assembled byte, valid with rx_valid
//  rx_valid      out  1   one-clk pulse per payload byte (DA..FCS)
//  rx_sof        out  1   one-clk pulse coincident with rx_valid of first byte
//  rx_eof        out  1   one-clk end-of-frame pulse; never coincident with rx_valid
//  rx_good       out  1   valid with rx_eof: CRC ok, length legal, aligned
//  rx_err_crc    out  1   valid with rx_eof: CRC residue mismatch
//  rx_err_len    out  1   valid with rx_eof: length <MIN_LEN or >MAX_LEN
//  rx_err_align  out  1   valid with rx_eof: odd nibble count in DATA
//  rx_len        out  11  valid with rx_eof: bytes received, saturates at 2047
//  rx_good_cnt   out  16  good-frame counter (see CONFIGURATION)
//  rx_bad_cnt    out  16  bad-frame counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0, CRC register = 0xFFFFFFFF, nibble phase 0, state DROP.
//    Data following reset is never decoded until rx_dv is seen low.
//  - All state advances only on clk with nib_en=1. Outputs are registered.
//  - Strobes rx_valid, rx_sof and rx_eof are high for exactly one clk. Status outputs hold until the next rx_eof.
//  - States:
//    IDLE: dv=1 & rxd=0x5 -> PRE (count=1); dv=1 & other rxd -> DROP.
//    PRE: dv=0 -> IDLE, no eof.
//      rxd=0x5 -> count++, saturating at 15.
//      rxd=0xD & count>=PRE_MIN -> DATA, phase 0, CRC preset.
//      Any other rxd -> DROP.
//    DATA, dv=1: phase 0 latches low nibble.
//      Phase 1 forms byte {rxd,low} and pulses rx_valid the next clk (sof on first byte).
//      Phase 1 also updates CRC (reflected poly 0x04C11DB7) and increments len.
//      Byte count reaching MAX_LEN+1: eof with err_len=1, then -> DROP. Excess bytes are not output.
//    DATA, dv=0 -> eof the next clk, then IDLE.
//      err_align = (phase==1); a dangling nibble is discarded.
//      err_crc = (CRC reg != residue 0xC704DD7B).
//      err_len = (len<MIN_LEN).
//      rx_good = no error.
//    DROP: dv=0 -> IDLE; no output.
//  - dv falling in PRE or IDLE produces no eof. A frame ending with zero bytes gives eof with err_len=1 and len=0.
//  - Synchronous reset mid-frame: no eof for the aborted frame.
//  - Latency: rx_valid one clk after the high-nibble strobe; rx_eof one clk after the dv=0 strobe.
// CONFIGURATION
//  MII_RX_STATS_EN defined:
//    rx_good_cnt increments on each eof with rx_good=1.
//    rx_bad_cnt increments on each eof with rx_good=0.
//    Both are 16-bit, saturate at 0xFFFF and clear on reset.
//  MII_RX_STATS_EN undefined: both outputs tied to 0 and counters are not built.
// TESTING
//  1 Reset release with rx_dv low; 7x0x5,0xD, then 64-byte frame with valid FCS
//    -> 64 rx_valid, sof on first, eof with good=1, len=64.
//  2 Same frame with one payload bit flipped -> eof good=0, err_crc=1, len=64.
//  3 Frame ending after an odd nibble -> err_align=1, dangling nibble not output.
//  4 Only 4 preamble nibbles, then 0xD -> DROP, no rx_valid or eof until next frame.
//    Next legal frame is received good.
//  5 1600-byte burst -> 1518 rx_valid, eof with err_len=1 at byte 1519, nothing further until dv low.
//  6 Assert resetn=0 mid-frame with dv held high -> no eof and no output until dv low.
//    With MII_RX_STATS_EN, after 3 good + 2 bad frames: good_cnt=3, bad_cnt=2.

Source files
------------

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles bytes low nibble first, checks CRC-32/length/alignment.
// Optional frame statistics counters are built when MII_RX_STATS_EN is defined.
module mii_rx_deframer #(
  parameter int PRE_MIN = 6,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        nib_en,
  input  logic [3:0]  rxd,
  input  logic        rx_dv,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_good,
  output logic        rx_err_crc,
  output logic        rx_err_len,
  output logic        rx_err_align,
  output logic [10:0] rx_len,
  output logic [15:0] rx_good_cnt,
  output logic [15:0] rx_bad_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  // MSB-first register fed LSB-first per byte; a good frame leaves this residue.
  localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[30:0], 1'b0} ^ ((r[31] ^ b[i]) ? CRC_POLY : 32'h0);
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  low_q, low_d;
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;
  logic        first_q, first_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic        good_q, good_d, err_crc_q, err_crc_d, err_len_q, err_len_d, err_align_q, err_align_d;
  logic [10:0] len_out_q, len_out_d;

  logic [31:0] crc_upd;
  logic [10:0] len_inc;
  logic        crc_bad, len_short;

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    phase_d     = phase_q;
    low_d       = low_q;
    crc_d       = crc_q;
    len_d       = len_q;
    first_d     = first_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    good_d      = good_q;
    err_crc_d   = err_crc_q;
    err_len_d   = err_len_q;
    err_align_d = err_align_q;
    len_out_d   = len_out_q;
    crc_upd     = crc_byte(crc_q, {rxd, low_q});
    len_inc     = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
    crc_bad     = (crc_q != CRC_RESIDUE);
    len_short   = (len_q < 11'(MIN_LEN));
    if (nib_en) begin
      unique case (state_q)
        IDLE: if (rx_dv) begin
          if (rxd == 4'h5) begin
            state_d   = PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = DROP;
          end
        end
        PRE: begin
          if (!rx_dv) begin
            state_d = IDLE;
          end else if (rxd == 4'h5) begin
            if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (rxd == 4'hD && pre_cnt_q >= 4'(PRE_MIN)) begin
            state_d = DATA;
            phase_d = 1'b0;
            crc_d   = '1;
            len_d   = '0;
            first_d = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
        DATA: begin
          if (!rx_dv) begin
            eof_d       = 1'b1;
            err_align_d = phase_q;
            err_crc_d   = crc_bad;
            err_len_d   = len_short;
            good_d      = !(phase_q || crc_bad || len_short);
            len_out_d   = len_q;
            state_d     = IDLE;
          end else if (!phase_q) begin
            low_d   = rxd;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_upd;
            len_d   = len_inc;
            // Oversize: the excess byte is swallowed and the frame closes here.
            if (len_inc == 11'(MAX_LEN + 1)) begin
              eof_d       = 1'b1;
              err_len_d   = 1'b1;
              err_align_d = 1'b0;
              err_crc_d   = (crc_upd != CRC_RESIDUE);
              good_d      = 1'b0;
              len_out_d   = len_inc;
              state_d     = DROP;
            end else begin
              valid_d = 1'b1;
              data_d  = {rxd, low_q};
              sof_d   = first_q;
              first_d = 1'b0;
            end
          end
        end
        default: if (!rx_dv) state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= DROP;
      pre_cnt_q   <= '0;
      phase_q     <= 1'b0;
      low_q       <= '0;
      crc_q       <= '1;
      len_q       <= '0;
      first_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      good_q      <= 1'b0;
      err_crc_q   <= 1'b0;
      err_len_q   <= 1'b0;
      err_align_q <= 1'b0;
      len_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      phase_q     <= phase_d;
      low_q       <= low_d;
      crc_q       <= crc_d;
      len_q       <= len_d;
      first_q     <= first_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      good_q      <= good_d;
      err_crc_q   <= err_crc_d;
      err_len_q   <= err_len_d;
      err_align_q <= err_align_d;
      len_out_q   <= len_out_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_sof       = sof_q;
  assign rx_eof       = eof_q;
  assign rx_good      = good_q;
  assign rx_err_crc   = err_crc_q;
  assign rx_err_len   = err_len_q;
  assign rx_err_align = err_align_q;
  assign rx_len       = len_out_q;

`ifdef MII_RX_STATS_EN
  logic [15:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;

  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (eof_d) begin
      if (good_d && good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
      if (!good_d && bad_cnt_q != 16'hFFFF) bad_cnt_d = bad_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign rx_good_cnt = good_cnt_q;
  assign rx_bad_cnt  = bad_cnt_q;
`else
  assign rx_good_cnt = '0;
  assign rx_bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Randomized bench for mii_rx_deframer; frames are modelled as byte lists with a software FCS.
module tb_mii_rx_deframer;
  localparam int PRE_MIN = 6;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        nib_en = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_good, rx_err_crc, rx_err_len, rx_err_align;
  logic [10:0] rx_len;
  logic [15:0] rx_good_cnt, rx_bad_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int overlap = 0;
  int exp_good_cnt = 0, exp_bad_cnt = 0;
  logic [10:0] last_len = '0;
  logic        last_good = 1'b0;

  logic [7:0]  got_b[$];
  bit          got_sof[$];
  logic [14:0] got_eof[$];

  mii_rx_deframer #(.PRE_MIN(PRE_MIN), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .resetn(resetn), .nib_en(nib_en), .rxd(rxd), .rx_dv(rx_dv),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof),
    .rx_good(rx_good), .rx_err_crc(rx_err_crc), .rx_err_len(rx_err_len),
    .rx_err_align(rx_err_align), .rx_len(rx_len),
    .rx_good_cnt(rx_good_cnt), .rx_bad_cnt(rx_bad_cnt)
  );

  always #10 clk = ~clk;

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      got_b.push_back(rx_data);
      got_sof.push_back(rx_sof);
    end
    if (rx_eof) got_eof.push_back({rx_good, rx_err_crc, rx_err_len, rx_err_align, rx_len});
    if (rx_valid && rx_eof) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard Ethernet CRC-32 (reflected), FCS sent least significant byte first.
  function automatic logic [31:0] eth_fcs(input bq_t b, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input bq_t b);
    logic [31:0] f;
    int n = b.size();
    if (n < 4) return 1'b0;
    f = eth_fcs(b, n - 4);
    return b[n-4] == f[7:0] && b[n-3] == f[15:8] && b[n-2] == f[23:16] && b[n-1] == f[31:24];
  endfunction

  function automatic bq_t mk_frame(input int payload);
    bq_t b;
    logic [31:0] f;
    for (int i = 0; i < payload; i++) b.push_back(8'($urandom));
    f = eth_fcs(b, payload);
    for (int i = 0; i < 4; i++) b.push_back(f[8*i +: 8]);
    return b;
  endfunction

  task automatic nib(input logic dv, input logic [3:0] d);
    repeat ($urandom_range(0, 2)) begin
      nib_en = 1'b0; rxd = 4'($urandom); rx_dv = 1'($urandom);
      @(posedge clk); #1;
    end
    nib_en = 1'b1; rx_dv = dv; rxd = d;
    @(posedge clk); #1;
    nib_en = 1'b0; rxd = 4'($urandom);
  endtask

  task automatic clear_mon();
    got_b.delete(); got_sof.delete(); got_eof.delete();
  endtask

  task automatic run_frame(input string name, input int pre_n, input bq_t b, input bit odd);
    bq_t eb;
    bit exp_eof = 1'b0, ovf = 1'b0;
    logic exp_good = 1'b0, exp_crc = 1'b0, exp_lerr = 1'b0, exp_align = 1'b0;
    logic [10:0] exp_len = '0;
    int nsof = 0;
    clear_mon();
    for (int i = 0; i < pre_n; i++) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    foreach (b[i]) begin
      nib(1'b1, b[i][3:0]);
      nib(1'b1, b[i][7:4]);
    end
    if (odd) nib(1'b1, 4'($urandom));
    repeat (3) nib(1'b0, 4'($urandom));
    repeat (4) begin @(posedge clk); #1; end

    if (pre_n >= PRE_MIN) begin
      exp_eof = 1'b1;
      if (b.size() > MAX_LEN) begin
        ovf = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) eb.push_back(b[i]);
        exp_len = 11'(MAX_LEN + 1); exp_lerr = 1'b1; exp_good = 1'b0;
      end else begin
        eb = b;
        exp_len = 11'(b.size());
        exp_lerr = b.size() < MIN_LEN;
        exp_align = odd;
        exp_crc = !fcs_ok(b);
        exp_good = !(exp_lerr || exp_align || exp_crc);
      end
      if (exp_good) exp_good_cnt++; else exp_bad_cnt++;
      last_len = exp_len; last_good = exp_good;
    end

    chk({name, ".nbytes"}, got_b.size(), eb.size());
    for (int i = 0; i < eb.size() && i < got_b.size(); i++)
      if (got_b[i] !== eb[i]) chk({name, ".byte"}, got_b[i], eb[i]);
    foreach (got_sof[i]) nsof += int'(got_sof[i]);
    chk({name, ".sof_cnt"}, nsof, (eb.size() > 0) ? 1 : 0);
    if (eb.size() > 0 && got_sof.size() > 0) chk({name, ".sof_first"}, got_sof[0], 1);
    chk({name, ".eof_cnt"}, got_eof.size(), exp_eof);
    if (exp_eof && got_eof.size() > 0) begin
      chk({name, ".good"},   got_eof[0][14], exp_good);
      chk({name, ".err_len"}, got_eof[0][12], exp_lerr);
      chk({name, ".len"},    got_eof[0][10:0], exp_len);
      if (!ovf) begin
        chk({name, ".err_crc"},   got_eof[0][13], exp_crc);
        chk({name, ".err_align"}, got_eof[0][11], exp_align);
      end
    end
    chk({name, ".len_hold"},  rx_len, last_len);
    chk({name, ".good_hold"}, rx_good, last_good);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".valid"}, rx_valid, 0);
    chk({name, ".sof"},   rx_sof, 0);
    chk({name, ".eof"},   rx_eof, 0);
    chk({name, ".good"},  rx_good, 0);
    chk({name, ".len"},   rx_len, 0);
    chk({name, ".data"},  rx_data, 0);
    chk({name, ".cnts"},  {rx_good_cnt, rx_bad_cnt}, 0);
  endtask

  initial begin
    bq_t f;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) nib(1'b0, 4'h0);

    f = mk_frame(60);
    run_frame("t1_good64", 7, f, 1'b0);
    f[10] = f[10] ^ 8'h08;
    run_frame("t2_crc", 7, f, 1'b0);
    run_frame("t3_align", 8, mk_frame(66), 1'b1);
    run_frame("t4_pre4", 4, mk_frame(60), 1'b0);
    run_frame("t4_next", 7, mk_frame(70), 1'b0);
    run_frame("pre5", 5, mk_frame(60), 1'b0);
    run_frame("pre6", 6, mk_frame(60), 1'b0);
    run_frame("short63", 7, mk_frame(59), 1'b0);
    run_frame("empty", 7, f[0:-1], 1'b0);
    run_frame("max1518", 7, mk_frame(MAX_LEN - 4), 1'b0);
    begin
      bq_t burst;
      for (int i = 0; i < 1600; i++) burst.push_back(8'($urandom));
      run_frame("t5_burst", 7, burst, 1'b0);
    end
    for (int k = 0; k < 12; k++) begin
      bq_t r = mk_frame($urandom_range(0, 140));
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, r.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      run_frame("rand", $urandom_range(6, 10), r, ($urandom_range(0, 4) == 0));
    end

    // Mid-frame reset with dv held high, followed by frame-like data that must stay ignored.
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    for (int i = 0; i < 20; i++) nib(1'b1, 4'($urandom));
    resetn = 1'b0;
    nib(1'b1, 4'h5);
    nib(1'b1, 4'h5);
    @(negedge clk);
    chk_quiet("t6_in_reset");
    @(posedge clk); #1;
    clear_mon();
    resetn = 1'b1;
    exp_good_cnt = 0; exp_bad_cnt = 0; last_len = '0; last_good = 1'b0;
    for (int i = 0; i < 7; i++) nib(1'b1, 4'h5);
    nib(1'b1, 4'hD);
    for (int i = 0; i < 80; i++) nib(1'b1, 4'($urandom));
    repeat (3) nib(1'b0, 4'h0);
    repeat (4) begin @(posedge clk); #1; end
    chk("t6.nbytes", got_b.size(), 0);
    chk("t6.eof_cnt", got_eof.size(), 0);
    run_frame("t6_after", 7, mk_frame(60), 1'b0);
    run_frame("t6_after2", 7, mk_frame(80), 1'b0);
    f = mk_frame(62);
    f[5] ^= 8'h01;
    run_frame("t6_bad", 7, f, 1'b0);
    run_frame("t6_after3", 9, mk_frame(100), 1'b0);
    run_frame("t6_bad2", 7, mk_frame(61), 1'b1);

`ifdef MII_RX_STATS_EN
    chk("good_cnt", rx_good_cnt, exp_good_cnt);
    chk("bad_cnt",  rx_bad_cnt,  exp_bad_cnt);
`else
    chk("good_cnt", rx_good_cnt, 0);
    chk("bad_cnt",  rx_bad_cnt,  0);
`endif
    chk("eof_valid_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
